// File: rtl/data_mem_responder_pkg.sv
// Shared word width, address convention and FSM encoding for the data-memory responder.
// Pure definitions: no timing and no flow control of its own.
package data_mem_responder_pkg;

  localparam int WORD_W     = 16;
  localparam int BYTE_SHIFT = 1;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Odd byte address or word index past the end of the array.
  function automatic logic addr_illegal(input logic [31:0] addr, input int depth);
    return addr[0] || ((addr >> BYTE_SHIFT) >= 32'(depth));
  endfunction

endpackage

// File: rtl/data_mem_responder_sp_ram.sv
// Single-port 16-bit data RAM: synchronous write, registered read, contents survive reset.
// Read data appears one clock after the address; no flow control.
module data_mem_responder_sp_ram
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder serving one 16-bit lw/sw at a time; response LATENCY+1 clocks after accept.
// Accepts only when idle; the response is held stable until rsp_ready.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int AW      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AW-1:0]     req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = $clog2(DEPTH);
  // One extra count covers the registered RAM read, so even LATENCY=0 answers one clock after accept.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, finish;
  logic              wr_q;
  logic [AW-1:0]     addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              addr_err;
  logic [IW-1:0]     ram_addr;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;
  logic              rsp_valid_q, rsp_err_q;
  logic [WORD_W-1:0] rsp_rdata_q;

  assign req_ready = (state_q == S_IDLE) && reset_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          finish  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign addr_err = addr_illegal(32'(addr_q), DEPTH);
  // Present the live request address while idle so the read is already under way at accept.
  assign ram_addr = (state_q == S_IDLE) ? IW'(req_addr >> BYTE_SHIFT) : IW'(addr_q >> BYTE_SHIFT);
  assign ram_we   = finish && wr_q && !addr_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (finish) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= addr_err;
        rsp_rdata_q <= (wr_q || addr_err) ? '0 : ram_rdata;
      end else if (state_q == S_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  data_mem_responder_sp_ram #(
    .DEPTH(DEPTH),
    .IW   (IW)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  a_rsp_hold: assert property (@(posedge clock) disable iff (!reset_n)
    rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_rdata) && $stable(rsp_err));

  a_no_overlap: assert property (@(posedge clock) disable iff (!reset_n)
    !(req_ready && rsp_valid));

endmodule
